regfile: RTL and testbench



---
 rtl/regfile_pkg.sv | 12 +
 rtl/decoder_5_32.sv | 33 +++
 rtl/regfile.sv | 77 +++++++
 tb/tb_regfile.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for decode, writeback and the regfile itself.
package regfile_pkg;

   localparam int unsigned WIDTH    = 64;
   localparam int unsigned NREGS    = 32;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned ZERO_REG = 31;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [WIDTH-1:0]  reg_data_t;

endpackage : regfile_pkg

// File: rtl/decoder_5_32.sv
// 5:32 one-hot decoder with enable, built from a 2:4 group decode and a 3:8 line decode.
module decoder_5_32 (
   input  logic        i_en,
   input  logic [4:0]  i_sel,
   output logic [31:0] o_onehot
);

   logic [3:0] w_grp;
   logic [7:0] w_low;

   // 2:4 group select on the upper bits; the enable gates the whole decode here
   always_comb begin
      w_grp = '0;
      w_grp[i_sel[4:3]] = i_en;
   end

   // 3:8 line select on the lower bits
   always_comb begin
      w_low = '0;
      w_low[i_sel[2:0]] = 1'b1;
   end

   // Combine group and line selects into the 32-bit one-hot output
   always_comb begin
      o_onehot = '0;
      for (int g = 0; g < 4; g++) begin
         for (int k = 0; k < 8; k++) begin
            o_onehot[g*8 + k] = w_grp[g] & w_low[k];
         end
      end
   end

endmodule : decoder_5_32

// File: rtl/regfile.sv
// 32 x 64-bit architectural register file: two combinational read ports with
// same-cycle write bypass, one synchronous write port, register 31 reads as zero.
module regfile
   import regfile_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                RegWrite,
   input  logic [ADDR_W-1:0]   WriteRegister,
   input  logic [WIDTH-1:0]    WriteData,
   input  logic [ADDR_W-1:0]   ReadRegister1,
   input  logic [ADDR_W-1:0]   ReadRegister2,
   output logic [WIDTH-1:0]    ReadData1,
   output logic [WIDTH-1:0]    ReadData2
);

   logic [NREGS-1:0] w_dec;
   logic [NREGS-1:0] w_we;
   logic [WIDTH-1:0] w_entry [NREGS];
   logic             w_wr_live;
   logic             w_byp1;
   logic             w_byp2;
   logic             w_unused_zero_we;

   decoder_5_32 u_dec (
      .i_en     (RegWrite),
      .i_sel    (WriteRegister),
      .o_onehot (w_dec)
   );

   // Per-register write enables; the zero register never gets one
   always_comb begin
      w_we = w_dec;
      w_we[ZERO_REG] = 1'b0;
   end

   // The zero register's decode line is intentionally left unconnected
   assign w_unused_zero_we = w_dec[ZERO_REG];

   // Storage: 31 enabled flops with async clear; the zero entry is a constant
   for (genvar i = 0; i < NREGS; i++) begin : g_reg
      if (i != ZERO_REG) begin : g_store
         logic [WIDTH-1:0] r_q;

         // Capture WriteData when this register is selected; reset clears immediately
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_q <= '0;
            end else if (w_we[i]) begin
               r_q <= WriteData;
            end
         end

         assign w_entry[i] = r_q;
      end else begin : g_zero
         assign w_entry[i] = '0;
      end
   end

   // A write is bypass-eligible only outside reset and when not aimed at the zero register
   assign w_wr_live = RegWrite && !reset && (WriteRegister != ADDR_W'(ZERO_REG));
   assign w_byp1    = w_wr_live && (WriteRegister == ReadRegister1);
   assign w_byp2    = w_wr_live && (WriteRegister == ReadRegister2);

   // Read muxes with bypass; forced to zero while reset is held
   always_comb begin
      ReadData1 = w_entry[ReadRegister1];
      ReadData2 = w_entry[ReadRegister2];
      if (w_byp1) ReadData1 = WriteData;
      if (w_byp2) ReadData2 = WriteData;
      if (reset) begin
         ReadData1 = '0;
         ReadData2 = '0;
      end
   end

endmodule : regfile

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile.
module tb_regfile;

   logic        clk;
   logic        reset;
   logic        RegWrite;
   logic [4:0]  WriteRegister;
   logic [63:0] WriteData;
   logic [4:0]  ReadRegister1;
   logic [4:0]  ReadRegister2;
   logic [63:0] ReadData1;
   logic [63:0] ReadData2;

   int n_checks = 0;
   int n_errors = 0;

   regfile dut (
      .clk           (clk),
      .reset         (reset),
      .RegWrite      (RegWrite),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
      .ReadRegister1 (ReadRegister1),
      .ReadRegister2 (ReadRegister2),
      .ReadData1     (ReadData1),
      .ReadData2     (ReadData2)
   );

   task automatic clk_rise();
      #5 clk = 1'b1;
   endtask

   task automatic clk_fall();
      #5 clk = 1'b0;
   endtask

   task automatic tick();
      clk_rise();
      clk_fall();
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      clk           = 1'b0;
      reset         = 1'b1;
      RegWrite      = 1'b0;
      WriteRegister = '0;
      WriteData     = '0;
      ReadRegister1 = 5'd0;
      ReadRegister2 = 5'd30;
      #3;
      check("init_rd1", ReadData1, 64'h0);
      check("init_rd2", ReadData2, 64'h0);
      reset = 1'b0;
      #2;

      // Fill X0..X30 with all ones
      RegWrite  = 1'b1;
      WriteData = 64'hFFFF_FFFF_FFFF_FFFF;
      for (int i = 0; i < 31; i++) begin
         WriteRegister = 5'(i);
         tick();
      end
      RegWrite = 1'b0;
      ReadRegister1 = 5'd0;
      ReadRegister2 = 5'd30;
      #1;
      check("fill_x0", ReadData1, 64'hFFFF_FFFF_FFFF_FFFF);
      check("fill_x30", ReadData2, 64'hFFFF_FFFF_FFFF_FFFF);

      // Reset with clk low clears everything immediately; bypass disabled
      reset = 1'b1;
      #1;
      for (int i = 0; i < 31; i++) begin
         ReadRegister1 = 5'(i);
         ReadRegister2 = 5'(30 - i);
         #1;
         check("rst_rd1", ReadData1, 64'h0);
         check("rst_rd2", ReadData2, 64'h0);
      end
      RegWrite      = 1'b1;
      WriteRegister = 5'd5;
      WriteData     = 64'h77;
      ReadRegister1 = 5'd5;
      #1;
      check("rst_no_bypass", ReadData1, 64'h0);
      RegWrite = 1'b0;
      reset    = 1'b0;
      #1;
      for (int i = 0; i < 31; i++) begin
         ReadRegister1 = 5'(i);
         #1;
         check("post_rst_clear", ReadData1, 64'h0);
      end

      // Basic write/read
      RegWrite      = 1'b1;
      WriteRegister = 5'd5;
      WriteData     = 64'h0123_4567_89AB_CDEF;
      tick();
      RegWrite      = 1'b0;
      ReadRegister1 = 5'd5;
      ReadRegister2 = 5'd6;
      #1;
      check("basic_x5", ReadData1, 64'h0123_4567_89AB_CDEF);
      check("basic_x6", ReadData2, 64'h0);

      // Zero register
      RegWrite      = 1'b1;
      WriteRegister = 5'd31;
      WriteData     = 64'hDEAD;
      ReadRegister1 = 5'd31;
      ReadRegister2 = 5'd31;
      #1;
      check("zero_pre_rd1", ReadData1, 64'h0);
      check("zero_pre_rd2", ReadData2, 64'h0);
      clk_rise();
      #1;
      check("zero_post_rd1", ReadData1, 64'h0);
      check("zero_post_rd2", ReadData2, 64'h0);
      clk_fall();
      RegWrite = 1'b0;
      #1;
      check("zero_idle_rd1", ReadData1, 64'h0);

      // Bypass
      RegWrite      = 1'b1;
      WriteRegister = 5'd7;
      WriteData     = 64'h1111;
      tick();
      RegWrite      = 1'b0;
      ReadRegister1 = 5'd7;
      ReadRegister2 = 5'd7;
      #1;
      check("byp_stored", ReadData1, 64'h1111);
      RegWrite  = 1'b1;
      WriteData = 64'h2222;
      #1;
      check("byp_pre_rd1", ReadData1, 64'h2222);
      check("byp_pre_rd2", ReadData2, 64'h2222);
      clk_rise();
      #1;
      check("byp_edge_rd1", ReadData1, 64'h2222);
      check("byp_edge_rd2", ReadData2, 64'h2222);
      clk_fall();
      RegWrite = 1'b0;
      #1;
      check("byp_after_rd1", ReadData1, 64'h2222);
      check("byp_after_rd2", ReadData2, 64'h2222);

      // Independent per-port bypass
      RegWrite      = 1'b1;
      WriteRegister = 5'd8;
      WriteData     = 64'hAAAA;
      ReadRegister1 = 5'd8;
      ReadRegister2 = 5'd7;
      #1;
      check("byp_ind_rd1", ReadData1, 64'hAAAA);
      check("byp_ind_rd2", ReadData2, 64'h2222);
      RegWrite = 1'b0;
      #1;
      check("byp_off_rd1", ReadData1, 64'h0);

      // Write disabled
      RegWrite      = 1'b0;
      WriteRegister = 5'd3;
      WriteData     = 64'h55;
      ReadRegister1 = 5'd3;
      #1;
      check("wdis_pre", ReadData1, 64'h0);
      tick();
      #1;
      check("wdis_post", ReadData1, 64'h0);

      // Reset mid-operation
      RegWrite      = 1'b1;
      WriteRegister = 5'd10;
      WriteData     = 64'hABCD;
      tick();
      RegWrite      = 1'b0;
      ReadRegister1 = 5'd10;
      ReadRegister2 = 5'd5;
      #1;
      check("mid_stored", ReadData1, 64'hABCD);
      clk_rise();
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_x10", ReadData1, 64'h0);
      check("mid_rst_x5", ReadData2, 64'h0);
      clk_fall();
      RegWrite      = 1'b1;
      WriteRegister = 5'd10;
      WriteData     = 64'h5;
      #1;
      check("mid_held_pre", ReadData1, 64'h0);
      tick();
      #1;
      check("mid_held_post", ReadData1, 64'h0);
      reset     = 1'b0;
      WriteData = 64'h1;
      #1;
      check("mid_rel_byp", ReadData1, 64'h1);
      check("mid_rel_x5", ReadData2, 64'h0);
      tick();
      RegWrite = 1'b0;
      #1;
      check("mid_rel_stored", ReadData1, 64'h1);
      ReadRegister2 = 5'd30;
      #1;
      check("mid_rel_x30", ReadData2, 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_regfile
